// File: rtl/pipereg_elastic.sv
// Elastic inter-stage pipeline register: valid/ready handshake, one skid entry,
// synchronous flush, and control bits forced to zero whenever the stage holds a bubble.
//
// state    | meaning
// ST_EMPTY | no live entry, out_valid=0
// ST_ONE   | main holds the live entry, skid empty
// ST_FULL  | main and skid both live, in_ready=0
module pipereg_elastic #(
    parameter int PAYLOAD_W = 108,
    parameter int CTRL_W    = 10,
    parameter bit CLR_DATA  = 1'b0
) (
    input  logic                 clk,
    input  logic                 nrst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [PAYLOAD_W-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [PAYLOAD_W-1:0] out_data,
    output logic [1:0]           occupancy
);
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    // Bits that survive a bubble-clear: datapath bits only, or nothing when CLR_DATA is set.
    localparam logic [PAYLOAD_W-1:0] CTRL_MASK = {PAYLOAD_W{1'b1}} >> (PAYLOAD_W - CTRL_W);
    localparam logic [PAYLOAD_W-1:0] KEEP_MASK = CLR_DATA ? '0 : ~CTRL_MASK;

    logic [1:0]           occ_q, occ_d;
    logic [PAYLOAD_W-1:0] main_q, main_d;
    logic [PAYLOAD_W-1:0] skid_q, skid_d;
    logic                 in_ready_q, in_ready_d;
    logic                 in_fire;
    logic                 out_fire;

    assign in_fire  = in_valid & in_ready_q;
    assign out_fire = (occ_q != ST_EMPTY) & out_ready;

    always_comb begin
        occ_d  = occ_q;
        main_d = main_q;
        skid_d = skid_q;
        if (flush) begin
            occ_d  = ST_EMPTY;
            main_d = main_q & KEEP_MASK;
            skid_d = skid_q & KEEP_MASK;
        end else begin
            case (occ_q)
                ST_EMPTY: begin
                    if (in_fire) begin
                        main_d = in_data;
                        occ_d  = ST_ONE;
                    end
                end
                ST_ONE: begin
                    if (in_fire && out_fire) begin
                        main_d = in_data;
                    end else if (in_fire) begin
                        skid_d = in_data;
                        occ_d  = ST_FULL;
                    end else if (out_fire) begin
                        main_d = main_q & KEEP_MASK;
                        occ_d  = ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (out_fire) begin
                        main_d = skid_q;
                        skid_d = skid_q & KEEP_MASK;
                        occ_d  = ST_ONE;
                    end
                end
                default: begin
                    main_d = main_q & KEEP_MASK;
                    skid_d = skid_q & KEEP_MASK;
                    occ_d  = ST_EMPTY;
                end
            endcase
        end
        // Registered ready: looks at next occupancy so no path from out_ready reaches in_ready.
        in_ready_d = (occ_d != ST_FULL);
    end

    always_ff @(posedge clk) begin
        if (!nrst) begin
            occ_q      <= ST_EMPTY;
            main_q     <= '0;
            skid_q     <= '0;
            in_ready_q <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
            in_ready_q <= in_ready_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = (occ_q != ST_EMPTY);
    assign out_data  = main_q;
    assign occupancy = occ_q;

endmodule

// File: tb/tb_pipereg_elastic.sv
// Bench for pipereg_elastic: directed scenarios with literal expectations, then random
// handshake traffic against a queue model; a CLR_DATA=1 twin shares all stimulus.
module tb_pipereg_elastic;
    localparam int PW = 108;
    localparam int CW = 10;

    logic          clk = 1'b0;
    logic          nrst = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic [PW-1:0] in_data = '0;
    logic          out_ready = 1'b0;

    logic          in_ready0, out_valid0, in_ready1, out_valid1;
    logic [PW-1:0] out_data0, out_data1;
    logic [1:0]    occ0, occ1;

    int n_cmp = 0;
    int n_fail = 0;
    bit chk_en = 1'b0;

    pipereg_elastic #(.PAYLOAD_W(PW), .CTRL_W(CW), .CLR_DATA(1'b0)) dut0 (
        .clk(clk), .nrst(nrst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready0), .in_data(in_data),
        .out_valid(out_valid0), .out_ready(out_ready), .out_data(out_data0),
        .occupancy(occ0));

    pipereg_elastic #(.PAYLOAD_W(PW), .CTRL_W(CW), .CLR_DATA(1'b1)) dut1 (
        .clk(clk), .nrst(nrst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready1), .in_data(in_data),
        .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
        .occupancy(occ1));

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: entries held in order, plus the registered ready it must present.
    logic [PW-1:0] q[$];
    bit            m_in_ready = 1'b0;

    always @(posedge clk) begin
        bit in_f, out_f;
        if (!nrst) begin
            q.delete();
            m_in_ready = 1'b0;
        end else begin
            in_f  = in_valid && m_in_ready;
            out_f = (q.size() > 0) && out_ready;
            if (flush) begin
                q.delete();
            end else begin
                if (out_f) void'(q.pop_front());
                if (in_f) q.push_back(in_data);
            end
            m_in_ready = (q.size() < 2);
        end
    end

    // Per-cycle compare against the model, plus hold-under-backpressure check.
    bit            prev_v = 1'b0, prev_r = 1'b0, prev_fl = 1'b0, prev_rst = 1'b0;
    logic [PW-1:0] prev_d = '0;

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_valid0", PW'(out_valid0), PW'(q.size() > 0));
            chk("m_valid1", PW'(out_valid1), PW'(q.size() > 0));
            chk("m_occ0", PW'(occ0), PW'(q.size()));
            chk("m_occ1", PW'(occ1), PW'(q.size()));
            chk("m_ready0", PW'(in_ready0), PW'(m_in_ready));
            chk("m_ready1", PW'(in_ready1), PW'(m_in_ready));
            if (q.size() > 0) begin
                chk("m_data0", out_data0, q[0]);
                chk("m_data1", out_data1, q[0]);
            end else begin
                chk("m_ctrl_zero0", PW'(out_data0[CW-1:0]), '0);
                chk("m_bubble1", out_data1, '0);
            end
            if (prev_v && !prev_r && !prev_fl && prev_rst) begin
                chk("hold_valid", PW'(out_valid0), PW'(1));
                chk("hold_data", out_data0, prev_d);
            end
        end
        prev_v   = out_valid0;
        prev_r   = out_ready;
        prev_fl  = flush;
        prev_rst = nrst;
        prev_d   = out_data0;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic look();
        @(negedge clk);
    endtask

    function automatic logic [PW-1:0] rnd_payload();
        logic [127:0] t;
        t = {$urandom, $urandom, $urandom, $urandom};
        return t[PW-1:0];
    endfunction

    initial begin
        // Reset
        repeat (3) step();
        chk_en = 1'b1;
        look();
        chk("rst_valid", PW'(out_valid0), PW'(0));
        chk("rst_data0", out_data0, '0);
        chk("rst_occ", PW'(occ0), PW'(0));
        chk("rst_ready", PW'(in_ready0), PW'(0));

        nrst = 1'b1;
        step();
        look();
        chk("rel_ready", PW'(in_ready0), PW'(1));

        // Single beat, 1-cycle latency then bubble
        in_valid = 1'b1; in_data = PW'(8'hA5); out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        look();
        chk("a5_valid", PW'(out_valid0), PW'(1));
        chk("a5_data", out_data0, PW'(8'hA5));
        step();
        look();
        chk("a5_bub_valid", PW'(out_valid0), PW'(0));
        chk("a5_bub_ctrl", PW'(out_data0[CW-1:0]), '0);
        chk("a5_bub_clr", out_data1, '0);

        // Streaming at full rate
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1; in_data = PW'(i);
            step();
            look();
            chk("str_data", out_data0, PW'(i));
            chk("str_occ", PW'(occ0), PW'(1));
            chk("str_ready", PW'(in_ready0), PW'(1));
        end
        in_valid = 1'b0;
        step();

        // Backpressure into FULL, then drain in order
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = PW'(1);
        step(); look();
        chk("bp_occ1", PW'(occ0), PW'(1));
        chk("bp_rdy1", PW'(in_ready0), PW'(1));
        in_data = PW'(2);
        step(); look();
        chk("bp_occ2", PW'(occ0), PW'(2));
        chk("bp_rdy2", PW'(in_ready0), PW'(0));
        in_data = PW'(3);
        step(); look();
        chk("bp_held_occ", PW'(occ0), PW'(2));
        chk("bp_held_data", out_data0, PW'(1));
        out_ready = 1'b1;
        step(); look();
        chk("dr_data2", out_data0, PW'(2));
        chk("dr_occ", PW'(occ0), PW'(1));
        chk("dr_rdy", PW'(in_ready0), PW'(1));
        step(); look();
        chk("dr_data3", out_data0, PW'(3));
        in_valid = 1'b0;
        step(); look();
        chk("dr_empty", PW'(occ0), PW'(0));

        // Flush from FULL with a payload offered
        out_ready = 1'b0; in_valid = 1'b1; in_data = PW'(8'h11);
        step();
        in_data = PW'(8'h22);
        step(); look();
        chk("fl_full", PW'(occ0), PW'(2));
        flush = 1'b1; in_data = PW'(8'h77);
        step();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        look();
        chk("fl_occ", PW'(occ0), PW'(0));
        chk("fl_valid", PW'(out_valid0), PW'(0));
        chk("fl_ctrl", PW'(out_data0[CW-1:0]), '0);
        chk("fl_clr", out_data1, '0);
        chk("fl_ready", PW'(in_ready0), PW'(1));
        repeat (3) step();

        // Reset while FULL with out_ready toggling
        out_ready = 1'b0; in_valid = 1'b1; in_data = PW'(8'h31);
        step();
        in_data = PW'(8'h32);
        step();
        in_valid = 1'b0;
        nrst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            out_ready = i[0];
            step(); look();
            chk("rf_valid", PW'(out_valid0), PW'(0));
            chk("rf_data0", out_data0, '0);
            chk("rf_data1", out_data1, '0);
            chk("rf_occ", PW'(occ0), PW'(0));
            chk("rf_ready", PW'(in_ready0), PW'(0));
        end
        nrst = 1'b1;
        step(); look();
        chk("rf_rel_ready", PW'(in_ready0), PW'(1));

        // Random traffic
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            in_data   = rnd_payload();
            flush     = ($urandom_range(0, 63) == 0);
            nrst      = ($urandom_range(0, 499) != 0);
            step();
        end
        flush = 1'b0; nrst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) step();
        look();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
